// File: rtl/fifo_rx.sv
// fifo_rx: receive-side byte FIFO.
// Deserialises the demodulated bit stream (LSB first, one bit per bit_valid
// strobe) into WIDTH-bit words, stores complete words in a DEPTH-entry memory,
// and lets the CPU drain them through a zero-wait-state APB read port.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   reset_n    asynchronous active-low reset
//   en_rx      reception enable; low holds the bit counter at 0
//   data_in    received bit, sampled when bit_valid = 1
//   bit_valid  single-cycle strobe, one per received bit
//   psel, penable, pwrite  APB control
//   prdata     APB read data (0 outside a successful read)
//   pready     always 1
//   pslverr    error on read-from-empty or any write access
//   mem_state  1 when at least one word is stored
//   overflow   sticky: a completed word was dropped on a full FIFO
module fifo_rx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_rx,
  input  logic             data_in,
  input  logic             bit_valid,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  output logic [WIDTH-1:0] prdata,
  output logic             pready,
  output logic             pslverr,
  output logic             mem_state,
  output logic             overflow
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = $clog2(WIDTH);

  logic [PTR_WIDTH:0]   r_wr_ptr;
  logic [PTR_WIDTH:0]   r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_bit_cnt;
  // Only the low WIDTH-1 bits are held; the final bit goes straight to memory.
  logic [WIDTH-2:0]     r_shift;
  logic                 r_overflow;
  logic [WIDTH-1:0]     r_mem [DEPTH];

  logic                 w_empty;
  logic                 w_full;
  logic                 w_take;
  logic                 w_last;
  logic                 w_byte_done;
  logic                 w_push;
  logic                 w_rd_access;
  logic                 w_wr_access;
  logic                 w_pop;
  logic [WIDTH-2:0]     w_shift_d;
  logic [WIDTH-1:0]     w_word;

  // Full/empty use the pre-edge pointers, so a same-cycle read neither
  // rescues a word on full nor sees a word arriving into an empty FIFO.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]) &&
                       (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]);

  assign w_take      = en_rx & bit_valid;
  assign w_last      = (r_bit_cnt == CNT_WIDTH'(WIDTH - 1));
  assign w_byte_done = w_take & w_last;
  assign w_push      = w_byte_done & ~w_full;
  assign w_word      = {data_in, r_shift};

  assign w_rd_access = psel & penable & ~pwrite;
  assign w_wr_access = psel & penable & pwrite;
  assign w_pop       = w_rd_access & ~w_empty;

  always_comb begin
    w_shift_d = r_shift;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (r_bit_cnt == CNT_WIDTH'(i)) begin
        w_shift_d[i] = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (!en_rx) begin
      r_bit_cnt <= '0;
    end else if (bit_valid) begin
      r_shift   <= w_shift_d;
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (PTR_WIDTH + 1)'(1);
      end
      if (w_byte_done && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (PTR_WIDTH + 1)'(1);
      end
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= w_word;
    end
  end

  always_comb begin
    prdata = '0;
    if (w_pop) begin
      prdata = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
    end
  end

  assign pslverr   = (w_rd_access & w_empty) | w_wr_access;
  assign pready    = 1'b1;
  assign mem_state = ~w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fifo_rx.sv
module tb_fifo_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en_rx = 1'b1;
  logic       data_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       mem_state;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb_q[$];
  logic       model_ovf = 1'b0;

  fifo_rx #(.WIDTH(8), .DEPTH(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_rx     (en_rx),
    .data_in   (data_in),
    .bit_valid (bit_valid),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .mem_state (mem_state),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] v);
    if (sb_q.size() >= 64) model_ovf = 1'b1;
    else sb_q.push_back(v);
  endtask

  task automatic strobe(input logic b);
    @(negedge clk);
    data_in   = b;
    bit_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) begin
      strobe(v[i]);
      repeat (gap - 1) idle();
    end
    if (gap == 1) idle();
    model_push(v);
  endtask

  task automatic apb_read(input string tag);
    logic [7:0] e;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_data"}, prdata, e);
      chk({tag, "_err"}, pslverr, 0);
    end else begin
      chk({tag, "_empty_data"}, prdata, 0);
      chk({tag, "_empty_err"}, pslverr, 1);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
    chk({tag, "_mem_state"}, mem_state, (sb_q.size() != 0));
  endtask

  // Last bit of v completes on the same edge that ends an APB read.
  task automatic read_with_byte(input string tag, input logic [7:0] v);
    logic [7:0] e;
    int         pre;
    for (int i = 0; i < 7; i++) strobe(v[i]);
    @(negedge clk);
    bit_valid = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    penable = 1'b1; data_in = v[7]; bit_valid = 1'b1;
    #1;
    pre = sb_q.size();
    if (pre > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_data"}, prdata, e);
      chk({tag, "_err"}, pslverr, 0);
    end else begin
      chk({tag, "_empty_data"}, prdata, 0);
      chk({tag, "_empty_err"}, pslverr, 1);
    end
    if (pre >= 64) model_ovf = 1'b1;
    else sb_q.push_back(v);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; bit_valid = 1'b0;
    #1;
    chk({tag, "_mem_state"}, mem_state, (sb_q.size() != 0));
    chk({tag, "_ovf"}, overflow, model_ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_prdata"}, prdata, 0);
    chk({tag, "_pslverr"}, pslverr, 0);
    chk({tag, "_pready"}, pready, 1);
    chk({tag, "_mem_state"}, mem_state, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #5 reset_n = 1'b0;
    bit_valid = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    check_reset_outputs(tag);
    sb_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Empty read and write attempt
    apb_read("empty_rd");
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk("wr_err", pslverr, 1);
    chk("wr_prdata", prdata, 0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    chk("wr_mem_state", mem_state, 0);

    // Single byte 0xA5 at 25-cycle spacing; mem_state rises after 8th strobe
    begin
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 0; i < 7; i++) begin
        strobe(v[i]);
        repeat (24) idle();
      end
      strobe(v[7]);
      #1;
      chk("a5_before_last", mem_state, 0);
      idle();
      #1;
      chk("a5_after_last", mem_state, 1);
      model_push(v);
      apb_read("a5_rd");
    end

    // Fill 65 bytes back-to-back; 65th is dropped
    for (int i = 0; i < 65; i++) begin
      send_byte(8'(i), 1);
      if (i == 63) begin
        #1;
        chk("fill_ovf_at_64", overflow, 0);
      end
    end
    #1;
    chk("fill_ovf_at_65", overflow, 1);
    // Read from full while a byte completes: that byte is still dropped
    read_with_byte("full_rd", 8'h41);
    for (int i = 1; i < 65; i++) apb_read("drain");
    chk("drain_ovf_sticky", overflow, 1);
    do_reset("rst_after_fill");

    // en_rx abort: partial byte discarded
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    idle();
    @(negedge clk);
    en_rx = 1'b0;
    @(negedge clk);
    en_rx = 1'b1;
    send_byte(8'h3C, 1);
    apb_read("abort_rd");
    apb_read("abort_rd2");

    // Byte completing into an empty FIFO is not readable that cycle
    read_with_byte("empty_sim", 8'h5A);
    apb_read("empty_sim_rd");

    // Simultaneous complete+read, 200 bytes, pointer wrap
    send_byte(8'hC3, 1);
    for (int i = 0; i < 200; i++) read_with_byte("sim", 8'((i * 37 + 11) & 8'hFF));
    apb_read("sim_last");
    chk("sim_no_ovf", overflow, 0);

    // Reset mid-byte with 2 bytes stored
    send_byte(8'h11, 3);
    send_byte(8'h22, 3);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    do_reset("rst_mid");
    apb_read("rst_mid_rd");
    send_byte(8'h81, 2);
    apb_read("rst_fresh_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rx.md
# fifo_rx

Receive-side byte FIFO for the Zigbee datapath, the counterpart of the transmit FIFO. It gathers the demodulated serial bit stream from the RX chain into bytes, LSB first, with one bit per `bit_valid` strobe at the 2 MHz chip-decision rate. Complete bytes are stored in a DEPTH-entry memory. The CPU drains that memory through an APB slave read port.

## Interface
Parameters:
- `WIDTH`, default 8: byte width; also the number of bits per assembled word.
- `DEPTH`, default 64: number of FIFO entries; must be a power of 2. `PTR_WIDTH = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  system clock, 50 MHz. One clock; everything is synchronous to its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `en_rx`  in  1  reception enable. Low means the bit counter is held at 0 and any partial byte is discarded.
- `data_in`  in  1  received bit. Sampled only when `bit_valid` = 1.
- `bit_valid`  in  1  single-cycle strobe, one per received bit.
- `psel`, `penable`, `pwrite`  in  1 each  APB control.
- `prdata`  out  WIDTH  APB read data.
- `pready`  out  1  tied to 1; the slave never inserts wait states.
- `pslverr`  out  1  APB error response.
- `mem_state`  out  1  0 = FIFO empty; 1 = at least one byte stored.
- `overflow`  out  1  sticky flag: a completed byte was dropped because the FIFO was full.

## Operation
- **Pointers:** `wr_ptr` and `rd_ptr` are each PTR_WIDTH+1 bits, with the MSB acting as the wrap bit.
  - empty = pointers fully equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap modulo 2·DEPTH with no special case.
- **Deserializer:** uses a 3-bit `bit_cnt` and a WIDTH-bit `shift_reg`.
  - On each cycle with `en_rx` = 1 and `bit_valid` = 1: `shift_reg[bit_cnt] <= data_in` and `bit_cnt` increments.
  - When `bit_cnt` = 7, the byte is complete. The full word `{data_in, shift_reg[6:0]}` is written to `mem[wr_ptr]` and `bit_cnt` returns to 0.
- **Byte write:** occurs only if full = 0, in which case `wr_ptr` increments.
  - If full = 1, the byte is dropped, `overflow` is set to 1, and `wr_ptr` is unchanged.
  - `bit_cnt` still returns to 0 either way.
- **en_rx low:** `bit_cnt` is forced to 0 and `bit_valid` is ignored. `shift_reg` contents are don't-care. FIFO contents and pointers are unaffected.
- **APB read access** (`psel` & `penable` & !`pwrite`):
  - Not empty: `prdata` = `mem[rd_ptr[PTR_WIDTH-1:0]]` combinationally, `pslverr` = 0, and `rd_ptr` increments at the clock edge ending the access.
  - Empty: `prdata` = 0, `pslverr` = 1, and `rd_ptr` is unchanged.
- **Outside a read access:** `prdata` = 0.
- **APB write access** (`psel` & `penable` & `pwrite`): `pslverr` = 1; no state changes.
- **`overflow`:** cleared only by reset.
- **Simultaneous byte completion and APB read, same cycle:** full and empty are evaluated on pre-edge pointers.
  - A read from a full FIFO does not rescue the incoming byte: it is dropped and `overflow` is set.
  - A byte completing into an empty FIFO is not readable in the same cycle: that read errors.
  - When the FIFO is neither full nor empty, both pointers advance in the same edge.
- **Memory:** has no reset requirement. Stale contents are never observable, because reads of an empty FIFO return 0.

## Timing
- **Reset values:**
  - outputs: `prdata` = 0, `pslverr` = 0, `pready` = 1, `mem_state` = 0, `overflow` = 0
  - internal: `wr_ptr` = `rd_ptr` = `bit_cnt` = 0
- **Write latency:** `mem_state` rises the cycle after the edge that samples the 8th `bit_valid`. It is combinational from the pointers.
- **Read latency:** `prdata` and `pslverr` are valid during the APB access phase, 0 wait states.
  - `mem_state` falls the cycle after the edge that consumes the last byte.
- **Throughput:**
  - Minimum sustained bit spacing is 1 cycle; back-to-back `bit_valid` is legal.
  - One APB read per 2 cycles (setup + access) drains faster than the 2 MHz stream fills.
- **Reset mid-byte or mid-transfer:** everything returns to reset values immediately (asynchronous). The partial byte is lost.

## Test plan
- **Single byte:** `en_rx` = 1; strobe bits 1,0,1,0,0,1,0,1 (0xA5, LSB first) at 25-cycle spacing.
  - `mem_state` = 1 one cycle after the 8th strobe.
  - APB read returns `prdata` = 0xA5 with `pslverr` = 0.
  - `mem_state` = 0 afterwards.
- **Fill and overflow:** receive 65 bytes with values 0x00..0x40.
  - `overflow` = 1 after the 65th byte.
  - 64 reads return 0x00..0x3F in order; the 65th read gives `pslverr` = 1, `prdata` = 0.
- **Empty read and write attempt:**
  - Read right after reset → `pslverr` = 1, `prdata` = 0, `rd_ptr` stays 0.
  - APB write of 0x55 → `pslverr` = 1, `mem_state` stays 0.
- **en_rx abort:** strobe 3 bits, drop `en_rx` for 1 cycle, raise it, then send 0x3C.
  - Exactly one byte is stored, equal to 0x3C.
- **Simultaneous events and wrap:** with 1 byte stored, complete a second byte in the same cycle as an APB read.
  - The read returns the first byte; `mem_state` stays 1; the next read returns the second.
  - Repeat for 200 bytes to exercise pointer wrap: all data arrives in order and `overflow` stays 0.
- **Reset mid-byte:** assert `reset_n` = 0 after 4 bits with 2 bytes stored.
  - All outputs return to reset values, and a subsequent read errors.
